// File: rtl/pac_motion_ctrl_if.sv
// Pac-Man motion controller bus: move/turn inputs, collision probe, committed sprite position.
// master = controller side, slave = the game/checker environment driving it.
interface pac_motion_ctrl_if;
    logic       move_tick;
    logic       dir_req_valid;
    logic [1:0] dir_req;
    logic [9:0] chk_x;
    logic [8:0] chk_y;
    logic [1:0] chk_dir;
    logic       chk_ok;
    logic [9:0] pac_x;
    logic [8:0] pac_y;
    logic [1:0] pac_dir;
    logic       moving;
    logic       busy;

    modport master (
        input  move_tick, dir_req_valid, dir_req, chk_ok,
        output chk_x, chk_y, chk_dir, pac_x, pac_y, pac_dir, moving, busy
    );

    modport slave (
        output move_tick, dir_req_valid, dir_req, chk_ok,
        input  chk_x, chk_y, chk_dir, pac_x, pac_y, pac_dir, moving, busy
    );
endinterface

// File: rtl/pac_motion_ctrl.sv
// Per-tick Pac-Man mover: probes a pending turn, then the current heading, and commits a saturating step.
// Straight move lands PROBE_LAT+1 clocks after the tick edge; ticks arriving while busy are dropped.
module pac_motion_ctrl #(
    parameter int START_X   = 304,
    parameter int START_Y   = 224,
    parameter int STEP      = 1,
    parameter int PROBE_LAT = 3,
    parameter int X_MAX     = 608,
    parameter int Y_MAX     = 448
) (
    input  logic              clk,
    input  logic              rst,
    pac_motion_ctrl_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREQ = 2'd1;
    localparam logic [1:0] S_PCUR = 2'd2;
    localparam logic [1:0] S_STEP = 2'd3;

    localparam logic [1:0] DIR_UP = 2'b00;
    localparam logic [1:0] DIR_DN = 2'b01;
    localparam logic [1:0] DIR_LF = 2'b10;
    localparam logic [1:0] DIR_RT = 2'b11;

    localparam int CW = $clog2(PROBE_LAT + 2);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          pend_valid;
    logic [1:0]    pend_dir;
    logic [9:0]    pac_x, chk_x;
    logic [8:0]    pac_y, chk_y;
    logic [1:0]    pac_dir, chk_dir;
    logic          moving;
    logic          sample;
    logic [10:0]   x_sum;
    logic [9:0]    y_sum;

    assign sample = (cnt == CW'(1));
    assign x_sum  = {1'b0, pac_x} + 11'(STEP);
    assign y_sum  = {1'b0, pac_y} + 10'(STEP);

    // A fresh strobe always overrides the clear that a granted turn would apply.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid <= 1'b0;
            pend_dir   <= DIR_LF;
        end else if (bus.dir_req_valid) begin
            pend_dir   <= bus.dir_req;
            pend_valid <= (bus.dir_req != pac_dir);
        end else if (state == S_PREQ && sample && bus.chk_ok) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pac_x   <= 10'(START_X);
            pac_y   <= 9'(START_Y);
            pac_dir <= DIR_LF;
            chk_x   <= 10'(START_X);
            chk_y   <= 9'(START_Y);
            chk_dir <= DIR_LF;
            moving  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.move_tick) begin
                    chk_x <= pac_x;
                    chk_y <= pac_y;
                    cnt   <= CW'(PROBE_LAT);
                    if (pend_valid && pend_dir != pac_dir) begin
                        chk_dir <= pend_dir;
                        state   <= S_PREQ;
                    end else begin
                        chk_dir <= pac_dir;
                        state   <= S_PCUR;
                    end
                end
                S_PREQ: if (sample) begin
                    if (bus.chk_ok) begin
                        pac_dir <= pend_dir;
                        state   <= S_STEP;
                    end else begin
                        // Fallback probe holds one extra clock so a rejected turn costs 2*PROBE_LAT+2.
                        chk_dir <= pac_dir;
                        cnt     <= CW'(PROBE_LAT + 1);
                        state   <= S_PCUR;
                    end
                end else begin
                    cnt <= cnt - CW'(1);
                end
                S_PCUR: if (sample) begin
                    if (bus.chk_ok) begin
                        state <= S_STEP;
                    end else begin
                        moving <= 1'b0;
                        state  <= S_IDLE;
                    end
                end else begin
                    cnt <= cnt - CW'(1);
                end
                S_STEP: begin
                    case (pac_dir)
                        DIR_UP: pac_y <= (pac_y < 9'(STEP)) ? 9'd0 : pac_y - 9'(STEP);
                        DIR_DN: pac_y <= (y_sum > 10'(Y_MAX)) ? 9'(Y_MAX) : y_sum[8:0];
                        DIR_LF: pac_x <= (pac_x < 10'(STEP)) ? 10'd0 : pac_x - 10'(STEP);
                        DIR_RT: pac_x <= (x_sum > 11'(X_MAX)) ? 10'(X_MAX) : x_sum[9:0];
                        default: ;
                    endcase
                    moving <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.chk_x   = chk_x;
    assign bus.chk_y   = chk_y;
    assign bus.chk_dir = chk_dir;
    assign bus.pac_x   = pac_x;
    assign bus.pac_y   = pac_y;
    assign bus.pac_dir = pac_dir;
    assign bus.moving  = moving;
    assign bus.busy    = (state != S_IDLE);
endmodule

// File: tb/tb_pac_motion_ctrl.sv
// Directed bench for pac_motion_ctrl: default instance plus two STEP=4 instances for edge clamping.
module tb_pac_motion_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_a = 1'b0, tick_b = 1'b0, tick_c = 1'b0;
    logic       req_vld = 1'b0;
    logic [1:0] req_dir = 2'b00;
    logic       ok = 1'b1;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    pac_motion_ctrl_if if_a ();
    pac_motion_ctrl_if if_b ();
    pac_motion_ctrl_if if_c ();

    assign if_a.move_tick = tick_a;
    assign if_b.move_tick = tick_b;
    assign if_c.move_tick = tick_c;
    assign if_a.dir_req_valid = req_vld;
    assign if_b.dir_req_valid = req_vld;
    assign if_c.dir_req_valid = req_vld;
    assign if_a.dir_req = req_dir;
    assign if_b.dir_req = req_dir;
    assign if_c.dir_req = req_dir;
    assign if_a.chk_ok = ok;
    assign if_b.chk_ok = ok;
    assign if_c.chk_ok = ok;

    pac_motion_ctrl u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    pac_motion_ctrl #(.START_X(606), .STEP(4)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
    pac_motion_ctrl #(.START_X(2),   .STEP(4)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [1:0] d);
        req_vld = 1'b1;
        req_dir = d;
        cyc(1);
        req_vld = 1'b0;
    endtask

    task automatic chk_reset_a(input string tag);
        chk_eq({tag, " pac_x"},   32'(if_a.pac_x),   304);
        chk_eq({tag, " pac_y"},   32'(if_a.pac_y),   224);
        chk_eq({tag, " pac_dir"}, 32'(if_a.pac_dir), 2);
        chk_eq({tag, " chk_x"},   32'(if_a.chk_x),   304);
        chk_eq({tag, " chk_y"},   32'(if_a.chk_y),   224);
        chk_eq({tag, " chk_dir"}, 32'(if_a.chk_dir), 2);
        chk_eq({tag, " moving"},  32'(if_a.moving),  0);
        chk_eq({tag, " busy"},    32'(if_a.busy),    0);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 chk_reset_a("rst");
        @(posedge clk);
        #1 rst = 1'b1;
        cyc(2);

        // Straight move left, chk_ok=1: E0 probe, step lands at E0+4.
        ok = 1'b1;
        tick_a = 1'b1; cyc(1); tick_a = 1'b0;
        chk_eq("t1 chk_dir E0", 32'(if_a.chk_dir), 2);
        chk_eq("t1 chk_x E0",   32'(if_a.chk_x),   304);
        chk_eq("t1 busy E0",    32'(if_a.busy),    1);
        cyc(3);
        chk_eq("t1 pac_x E3",   32'(if_a.pac_x),   304);
        cyc(1);
        chk_eq("t1 pac_x E4",   32'(if_a.pac_x),   303);
        chk_eq("t1 moving",     32'(if_a.moving),  1);
        chk_eq("t1 busy after", 32'(if_a.busy),    0);

        // Turn up granted on first probe.
        strobe(2'b00);
        tick_a = 1'b1; cyc(1); tick_a = 1'b0;
        chk_eq("t2 chk_dir",  32'(if_a.chk_dir), 0);
        cyc(4);
        chk_eq("t2 pac_dir",  32'(if_a.pac_dir), 0);
        chk_eq("t2 pac_y",    32'(if_a.pac_y),   223);
        chk_eq("t2 pac_x",    32'(if_a.pac_x),   303);
        chk_eq("t2 pend clr", 32'(u_dut_a.pend_valid), 0);

        // Turn right rejected, straight up granted: step at E0+8.
        strobe(2'b11);
        ok = 1'b0;
        tick_a = 1'b1; cyc(1); tick_a = 1'b0;
        chk_eq("t3 chk_dir req", 32'(if_a.chk_dir), 3);
        cyc(3);
        chk_eq("t3 chk_dir cur", 32'(if_a.chk_dir), 0);
        ok = 1'b1;
        cyc(4);
        chk_eq("t3 pac_y E7",    32'(if_a.pac_y),   223);
        cyc(1);
        chk_eq("t3 pac_y E8",    32'(if_a.pac_y),   222);
        chk_eq("t3 pac_dir",     32'(if_a.pac_dir), 0);

        // Pending right kept; both probes blocked leaves Pac-Man still.
        ok = 1'b0;
        tick_a = 1'b1; cyc(1); tick_a = 1'b0;
        chk_eq("t4 reprobe dir", 32'(if_a.chk_dir), 3);
        cyc(7);
        chk_eq("t4 moving",  32'(if_a.moving),  0);
        chk_eq("t4 busy",    32'(if_a.busy),    0);
        chk_eq("t4 pac_x",   32'(if_a.pac_x),   303);
        chk_eq("t4 pac_y",   32'(if_a.pac_y),   222);
        chk_eq("t4 pac_dir", 32'(if_a.pac_dir), 0);

        // Same-direction strobe cancels the pending turn; a tick mid-probe is dropped.
        strobe(2'b00);
        chk_eq("t5 pend clr", 32'(u_dut_a.pend_valid), 0);
        ok = 1'b1;
        tick_a = 1'b1; cyc(1); tick_a = 1'b0;
        cyc(1);
        tick_a = 1'b1; cyc(1); tick_a = 1'b0;
        cyc(2);
        chk_eq("t5 pac_y one", 32'(if_a.pac_y), 221);
        cyc(8);
        chk_eq("t5 pac_y still", 32'(if_a.pac_y), 221);
        chk_eq("t5 busy idle",   32'(if_a.busy),  0);

        // Async reset mid PROBE_CUR.
        tick_a = 1'b1; cyc(1); tick_a = 1'b0;
        cyc(1);
        chk_eq("t6 busy pre", 32'(if_a.busy), 1);
        rst = 1'b0;
        #1 chk_reset_a("t6 async");
        cyc(1);
        rst = 1'b1;
        cyc(6);
        chk_eq("t6 no self start", 32'(if_a.busy),  0);
        chk_eq("t6 pac_x hold",    32'(if_a.pac_x), 304);

        // Left clamp at 0 with STEP=4.
        ok = 1'b1;
        tick_c = 1'b1; cyc(1); tick_c = 1'b0;
        cyc(4);
        chk_eq("c left clamp",  32'(if_c.pac_x), 0);
        chk_eq("b untouched",   32'(if_b.pac_x), 606);
        tick_c = 1'b1; cyc(1); tick_c = 1'b0;
        cyc(4);
        chk_eq("c left stay 0", 32'(if_c.pac_x), 0);

        // Turn right and clamp at X_MAX with STEP=4.
        strobe(2'b11);
        tick_b = 1'b1; cyc(1); tick_b = 1'b0;
        chk_eq("b chk_dir",      32'(if_b.chk_dir), 3);
        cyc(4);
        chk_eq("b pac_dir",      32'(if_b.pac_dir), 3);
        chk_eq("b right clamp",  32'(if_b.pac_x),   608);
        tick_b = 1'b1; cyc(1); tick_b = 1'b0;
        cyc(4);
        chk_eq("b right stay",   32'(if_b.pac_x),   608);
        chk_eq("b moving",       32'(if_b.moving),  1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pac_motion_ctrl.md
Name: pac_motion_ctrl

Overview:
- Per-frame Pac-Man movement controller and the initiator side of the wall-collision probe.
- Each move tick it presents a candidate position and direction to the collision checker, waits out the checker's pipeline, and samples the move-allowed flag.
- It first tries a pending turn request; if the turn is blocked it retries the current heading.
- It commits a one-step position update or stalls. It feeds the sprite renderer with pac_x, pac_y and pac_dir.

Parameters:
- START_X, 304: reset X of the sprite's top-left corner (10 bit).
- START_Y, 224: reset Y of the sprite's top-left corner (9 bit).
- STEP, 1: pixels moved per granted tick (1..8).
- PROBE_LAT, 3: clocks from a chk_* change to a valid chk_ok (minimum 2).
- X_MAX, 608: largest legal pac_x (640 minus 32).
- Y_MAX, 448: largest legal pac_y (480 minus 32).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- move_tick  input  1  one-cycle pulse, movement rate
- dir_req_valid  input  1  direction request strobe
- dir_req  input  2  requested direction: 00 up, 01 down, 10 left, 11 right
- chk_x  output  10  probe X to collision checker
- chk_y  output  9  probe Y to collision checker
- chk_dir  output  2  probe direction, same encoding as dir_req
- chk_ok  input  1  checker result: 1 = no wall in probed direction
- pac_x  output  10  committed X
- pac_y  output  9  committed Y
- pac_dir  output  2  committed heading
- moving  output  1  1 if the last tick produced a step
- busy  output  1  1 while not IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - pac_x=chk_x=START_X; pac_y=chk_y=START_Y.
  - pac_dir=chk_dir=2'b10.
  - pend_valid=0; moving=0; busy=0; wait counter=0.
- Pending request register:
  - Any cycle with dir_req_valid=1 loads pend_dir=dir_req and sets pend_valid=1; the newest request wins, including while busy.
  - If dir_req equals pac_dir, pend_valid is cleared instead.
  - If a strobe coincides with the PROBE_REQ sample edge, the strobe's value wins.
- States: IDLE, PROBE_REQ, PROBE_CUR, STEP.
- IDLE, on move_tick:
  - If pend_valid and pend_dir != pac_dir: go to PROBE_REQ, driving chk_dir=pend_dir.
  - Otherwise: go to PROBE_CUR, driving chk_dir=pac_dir.
  - In both cases chk_x=pac_x, chk_y=pac_y, and the counter is loaded with PROBE_LAT.
  - move_tick while not IDLE is dropped; no queuing.
- PROBE_REQ / PROBE_CUR:
  - The counter decrements each clock.
  - chk_ok is sampled on the edge where the counter is 1, i.e. PROBE_LAT edges after chk_* changed.
  - chk_* stay constant throughout the probe.
- PROBE_REQ result:
  - chk_ok=1: pac_dir<=pend_dir, pend_valid<=0, go to STEP.
  - chk_ok=0: re-drive chk_dir=pac_dir, reload the counter, go to PROBE_CUR. The pending request is kept.
- PROBE_CUR result:
  - chk_ok=1: go to STEP.
  - chk_ok=0: moving<=0, go to IDLE.
- STEP (one cycle):
  - Update per pac_dir, saturating:
    - up: pac_y = (pac_y < STEP) ? 0 : pac_y-STEP
    - down: min(pac_y+STEP, Y_MAX)
    - left: (pac_x < STEP) ? 0 : pac_x-STEP
    - right: min(pac_x+STEP, X_MAX)
  - Compute sums at 11/10 bits before clamping; no wrap-around.
  - moving<=1, go to IDLE.
- Latency: with move_tick high in the cycle before edge E0, chk_* change at E0.
  - Straight move: pac updates at E0+PROBE_LAT+1.
  - Rejected turn then straight move: pac updates at E0+2*PROBE_LAT+2.
- busy=1 in PROBE_REQ, PROBE_CUR and STEP.
- pac_* change only on a STEP edge or a granted turn; chk_* otherwise hold their last value.
- Reset asserted mid-probe aborts immediately to reset values. After release, the first action waits for a fresh move_tick.

Test Plan:
- Reset release, no requests, chk_ok=1, one tick:
  - chk_dir=10 and chk_x=304 at E0.
  - pac_x=303 at E0+4.
  - moving=1; busy low after the STEP edge.
- dir_req=00 strobe, then tick, chk_ok=1:
  - PROBE_REQ only; pac_dir=00 and pac_y=223.
  - pend_valid cleared.
- dir_req=00, tick, chk_ok=0 during PROBE_REQ and 1 during PROBE_CUR:
  - pac_dir stays 10 and pac_x decrements at E0+8.
  - The next tick probes 00 again.
- chk_ok=0 on both probes:
  - pac_x, pac_y and pac_dir unchanged; moving=0.
- pac_x=608, dir right, STEP=4, chk_ok=1:
  - pac_x stays 608.
- pac_x=2, left, STEP=4:
  - pac_x=0.
- Second move_tick during a probe is ignored (exactly one step).
- rst pulsed low mid-PROBE_CUR:
  - All outputs return to reset values asynchronously.
